// File: rtl/ppi_bus_master.sv
// ppi_bus_master
//   CPU-side initiator for the 8255 PPI. A valid/ready request is turned into
//   one timed bus cycle: SETUP (address/CS_n/data stable), STROBE (RD_n or
//   WR_n low), HOLD (strobe high, address/data still stable), RECOVER (CS_n
//   high). Completion is a one-cycle rsp_valid pulse in the first IDLE cycle.
//
//   Request handshake: a request transfers on a rising CLK edge where
//   req_valid and req_ready are both 1. req_ready is 1 only in IDLE.
//   req_write/req_addr/req_wdata are captured on that edge and ignored
//   afterwards. The requester may hold req_valid high across the
//   completion cycle to issue back-to-back accesses.
//
//   Optional build macro INIT_CFG_EN: after reset, perform one write of
//   INIT_CTRL_WORD to the control register (A = 11) before accepting
//   requests. That write produces no rsp_valid.
//
//   Ports:
//     CLK, RESET        clock; synchronous active-high reset
//     req_valid/ready   request handshake
//     req_write         1 = write, 0 = read
//     req_addr[1:0]     00 port A, 01 port B, 10 port C, 11 control
//     req_wdata[7:0]    write data
//     rsp_valid         one-cycle completion pulse
//     rsp_rdata[7:0]    data of the most recent read
//     busy              1 whenever the FSM is not IDLE
//     A, CS_n, RD_n,
//     WR_n, DATA        8255 bus; DATA is driven only during write cycles
module ppi_bus_master #(
  parameter int SETUP_CYC          = 1,
  parameter int STROBE_CYC         = 2,
  parameter int HOLD_CYC           = 1,
  parameter int RECOVER_CYC        = 1,
  parameter logic [7:0] INIT_CTRL_WORD = 8'h9B
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [1:0] A,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  inout  wire  [7:0] DATA
);

  // A zero-length phase is stretched to one cycle. The shared down-counter
  // is loaded with (length - 1) on state entry; the state ends when it hits 0.
  localparam int SETUP_EFF   = (SETUP_CYC   < 1) ? 1 : SETUP_CYC;
  localparam int STROBE_EFF  = (STROBE_CYC  < 1) ? 1 : STROBE_CYC;
  localparam int HOLD_EFF    = (HOLD_CYC    < 1) ? 1 : HOLD_CYC;
  localparam int RECOVER_EFF = (RECOVER_CYC < 1) ? 1 : RECOVER_CYC;

  localparam logic [7:0] L_SETUP   = 8'(SETUP_EFF - 1);
  localparam logic [7:0] L_STROBE  = 8'(STROBE_EFF - 1);
  localparam logic [7:0] L_HOLD    = 8'(HOLD_EFF - 1);
  localparam logic [7:0] L_RECOVER = 8'(RECOVER_EFF - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RECOVER
`ifdef INIT_CFG_EN
    , S_INIT
`endif
  } state_t;

`ifdef INIT_CFG_EN
  localparam state_t RESET_STATE = S_INIT;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_accept;
  logic [7:0] r_cnt;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_write;
  logic [7:0] r_rdata;
  logic       r_rsp_valid;
  logic       w_cnt_done;
  logic       w_drive;
  logic       w_cs_active;
  logic       w_suppress_rsp;

`ifdef INIT_CFG_EN
  // Marks the startup control-word write so it does not raise rsp_valid.
  logic r_init_acc;
  assign w_suppress_rsp = r_init_acc;
`else
  assign w_suppress_rsp = 1'b0;
`endif

  function automatic logic [7:0] load_for(input state_t s);
    case (s)
      S_SETUP:   load_for = L_SETUP;
      S_STROBE:  load_for = L_STROBE;
      S_HOLD:    load_for = L_HOLD;
      S_RECOVER: load_for = L_RECOVER;
      default:   load_for = 8'd0;
    endcase
  endfunction

  assign w_cnt_done = (r_cnt == 8'd0);

  // Next-state logic
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next   = S_SETUP;
          w_accept = 1'b1;
        end
      end
      S_SETUP:   if (w_cnt_done) w_next = S_STROBE;
      S_STROBE:  if (w_cnt_done) w_next = S_HOLD;
      S_HOLD:    if (w_cnt_done) w_next = S_RECOVER;
      S_RECOVER: if (w_cnt_done) w_next = S_IDLE;
`ifdef INIT_CFG_EN
      S_INIT:    w_next = S_SETUP;
`endif
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= RESET_STATE;
      r_cnt       <= 8'd0;
      r_addr      <= 2'b00;
      r_wdata     <= 8'h00;
      r_write     <= 1'b0;
      r_rdata     <= 8'h00;
      r_rsp_valid <= 1'b0;
`ifdef INIT_CFG_EN
      r_init_acc  <= 1'b1;
`endif
    end else begin
      r_state <= w_next;

      if (w_next != r_state) begin
        r_cnt <= load_for(w_next);
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - 8'd1;
      end

      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
      end

`ifdef INIT_CFG_EN
      if (r_state == S_INIT) begin
        r_addr  <= 2'b11;
        r_wdata <= INIT_CTRL_WORD;
        r_write <= 1'b1;
      end
      if (r_state == S_RECOVER && w_cnt_done) begin
        r_init_acc <= 1'b0;
      end
`endif

      // Sample on the edge that ends the last strobe cycle, RD_n still low.
      if (r_state == S_STROBE && w_cnt_done && !r_write) begin
        r_rdata <= DATA;
      end

      r_rsp_valid <= (r_state == S_RECOVER) && w_cnt_done && !w_suppress_rsp;
    end
  end

  assign w_cs_active = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                       (r_state == S_HOLD);
  assign w_drive     = w_cs_active && r_write;

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign A         = r_addr;
  assign CS_n      = !w_cs_active;
  assign WR_n      = !((r_state == S_STROBE) && r_write);
  assign RD_n      = !((r_state == S_STROBE) && !r_write);
  assign DATA      = w_drive ? r_wdata : 8'bzzzz_zzzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
module tb_ppi_bus_master;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [1:0] req_addr = 2'b00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [1:0] A;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  wire  [7:0] DATA;

  // PPI-side model: drives its port value only while RD_n is low.
  logic [7:0] ppi_val = 8'h00;
  assign DATA = (!RD_n) ? ppi_val : 8'bzzzz_zzzz;

  int n_pass  = 0;
  int n_total = 0;

  ppi_bus_master dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .A         (A),
    .CS_n      (CS_n),
    .RD_n      (RD_n),
    .WR_n      (WR_n),
    .DATA      (DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       write;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] ppi;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic chk_ne(input string name, input logic [7:0] act, input logic [7:0] bad);
    n_total++;
    if (act !== bad) n_pass++;
    else $display("FAIL %s: got %02h expected anything but %02h", name, act, bad);
  endtask

  // Expected bus view in cycle c after the accept edge
  // (1 SETUP, 2-3 STROBE, 4 HOLD, 5 RECOVER, 6 first IDLE).
  task automatic check_phase(input int c, input logic w, input logic [1:0] a,
                             input logic [7:0] wd, input logic [7:0] er);
    string p;
    p = $sformatf("c%0d_%s%0d", c, w ? "wr" : "rd", a);
    if (c >= 1 && c <= 4) begin
      chk({p, "_cs_n"}, {7'd0, CS_n}, 8'd0);
      chk({p, "_a"}, {6'd0, A}, {6'd0, a});
      chk({p, "_busy"}, {7'd0, busy}, 8'd1);
      chk({p, "_ready"}, {7'd0, req_ready}, 8'd0);
      chk({p, "_wr_n"}, {7'd0, WR_n}, (w && (c == 2 || c == 3)) ? 8'd0 : 8'd1);
      chk({p, "_rd_n"}, {7'd0, RD_n}, (!w && (c == 2 || c == 3)) ? 8'd0 : 8'd1);
      if (w) chk({p, "_data"}, DATA, wd);
    end else if (c == 5) begin
      chk({p, "_cs_n"}, {7'd0, CS_n}, 8'd1);
      chk({p, "_a_kept"}, {6'd0, A}, {6'd0, a});
      chk({p, "_busy"}, {7'd0, busy}, 8'd1);
      chk({p, "_rsp_valid"}, {7'd0, rsp_valid}, 8'd0);
      chk({p, "_strobes"}, {6'd0, RD_n, WR_n}, 8'd3);
      if (w) chk_ne({p, "_data_released"}, DATA, wd);
    end else begin
      chk({p, "_rsp_valid"}, {7'd0, rsp_valid}, 8'd1);
      chk({p, "_ready"}, {7'd0, req_ready}, 8'd1);
      chk({p, "_busy"}, {7'd0, busy}, 8'd0);
      chk({p, "_cs_n"}, {7'd0, CS_n}, 8'd1);
      chk({p, "_rdata"}, rsp_rdata, er);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_total++;
    if (req_ready) n_pass++;
    else $display("FAIL %s_ready_timeout: req_ready=%0b after %0d cycles, expected 1", name, req_ready, n);
  endtask

  task automatic do_access(input logic w, input logic [1:0] a, input logic [7:0] wd,
                           input logic [7:0] pv, input logic [7:0] er);
    wait_ready("access");
    ppi_val   = pv;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    @(posedge CLK);
    #1;
    // Scramble inputs after acceptance; the master must use its latched copy.
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = ~a;
    req_wdata = ~wd;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      check_phase(c, w, a, wd, er);
    end
    @(negedge CLK);
    chk("rsp_valid_one_cycle", {7'd0, rsp_valid}, 8'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b11, 8'h80, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 2'b00, 8'h00, 8'h5A, 8'h5A};
    vecs[2] = '{1'b1, 2'b01, 8'h11, 8'hEE, 8'h5A};
    vecs[3] = '{1'b0, 2'b10, 8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{1'b1, 2'b10, 8'hFF, 8'h00, 8'hC3};
    vecs[5] = '{1'b0, 2'b11, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 2'b01, 8'h00, 8'hA5, 8'hA5};

    // Reset: three cycles
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_cs_n", {7'd0, CS_n}, 8'd1);
    chk("rst_rd_n", {7'd0, RD_n}, 8'd1);
    chk("rst_wr_n", {7'd0, WR_n}, 8'd1);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
`ifdef INIT_CFG_EN
    begin
      int n_wr;
      int n_rsp;
      int n;
      n_wr = 0;
      n_rsp = 0;
      n = 0;
      chk("init_ready_low", {7'd0, req_ready}, 8'd0);
      chk("init_busy", {7'd0, busy}, 8'd1);
      while (!req_ready && n < 30) begin
        if (!WR_n) begin
          n_wr++;
          chk("init_a", {6'd0, A}, 8'd3);
          chk("init_data", DATA, 8'h9B);
        end
        if (rsp_valid) n_rsp++;
        @(negedge CLK);
        n++;
      end
      chk("init_ready_high", {7'd0, req_ready}, 8'd1);
      chk("init_wr_cycles", 8'(n_wr), 8'd2);
      chk("init_no_rsp", 8'(n_rsp) | {7'd0, rsp_valid}, 8'd0);
    end
`else
    chk("rst_a", {6'd0, A}, 8'd0);
    chk("rst_ready", {7'd0, req_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
`endif

    // Table-driven single accesses
    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].ppi, vecs[i].exp_rdata);
    end

    // Back-to-back: write B=33, then read C with req_valid held high
    wait_ready("b2b");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'b01;
    req_wdata = 8'h33;
    @(posedge CLK);
    #1;
    req_write = 1'b0;
    req_addr  = 2'b10;
    req_wdata = 8'h44;
    ppi_val   = 8'h77;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      check_phase(c, 1'b1, 2'b01, 8'h33, 8'hA5);
    end
    @(posedge CLK);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      check_phase(c, 1'b0, 2'b10, 8'h00, 8'h77);
    end

    // Reset in the middle of a write strobe
    @(negedge CLK);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2'b01;
    req_wdata = 8'hA5;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    check_phase(1, 1'b1, 2'b01, 8'hA5, 8'h00);
    @(negedge CLK);
    check_phase(2, 1'b1, 2'b01, 8'hA5, 8'h00);
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_wr_n", {7'd0, WR_n}, 8'd1);
    chk("abort_cs_n", {7'd0, CS_n}, 8'd1);
    chk_ne("abort_data_released", DATA, 8'hA5);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_rdata", rsp_rdata, 8'h00);
    RESET = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk($sformatf("abort_no_rsp_%0d", c), {7'd0, rsp_valid}, 8'd0);
    end
    do_access(1'b0, 2'b00, 8'h00, 8'h3C, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ppi_bus_master.md
Name: ppi_bus_master

Overview:
- CPU-side bus initiator for the 8255 PPI block. It converts a simple valid/ready request interface into timed 8255 bus cycles on A, CS_n, RD_n, WR_n and DATA.
- Handles control-word writes, port writes and port reads, returning read data and write completion to the requester.
- Sits between the system sequencer/CPU model and the PPI instance.

Parameters:
- SETUP_CYC, 1: cycles A/CS_n/DATA are stable before the strobe asserts (0 treated as 1).
- STROBE_CYC, 2: cycles RD_n or WR_n is held low (0 treated as 1).
- HOLD_CYC, 1: cycles A/CS_n/DATA are held after the strobe deasserts (0 treated as 1).
- RECOVER_CYC, 1: idle cycles with CS_n high before the next access (0 treated as 1).
- INIT_CTRL_WORD, 8'h9B: control word written at startup when INIT_CFG_EN is defined (9B = mode 0, all ports input).

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  2  PPI address: 00 port A, 01 port B, 10 port C, 11 control.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse when an accepted request completes.
- rsp_rdata  out  8  last read data.
- busy  out  1  high whenever the state is not IDLE.
- A  out  2  PPI address bus.
- CS_n  out  1  chip select, active-low.
- RD_n  out  1  read strobe, active-low.
- WR_n  out  1  write strobe, active-low.
- DATA  inout  8  PPI data bus; driven only during write cycles.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - State goes to IDLE, or INIT when INIT_CFG_EN is defined.
  - CS_n, RD_n and WR_n = 1; A = 00; DATA released (high-Z).
  - rsp_valid = 0; rsp_rdata = 8'h00; all counters cleared.
  - Reset mid-access aborts the access: strobes deassert at that edge and no rsp_valid is issued.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted on an edge with req_valid & req_ready.
  - req_addr, req_write and req_wdata are latched into internal registers at acceptance; inputs are don't-care afterwards.
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE.
  - Each non-IDLE state lasts its parameter count, tracked by one shared down-counter reloaded on every state entry.
- Per-state outputs:
  - SETUP: CS_n = 0; A = latched address; DATA driven with latched data if write.
  - STROBE: as SETUP, plus WR_n = 0 (write) or RD_n = 0 (read).
  - HOLD: strobe high again; CS_n, A and DATA (write) unchanged.
  - RECOVER: CS_n = 1; DATA released; A keeps its last value.
- Read capture: DATA is sampled into rsp_rdata at the clock edge that ends the last STROBE cycle, while RD_n is still low. Writes never modify rsp_rdata.
- Completion: rsp_valid = 1 for exactly the first IDLE cycle after RECOVER, for both reads and writes. req_ready is also 1 in that cycle, so back-to-back acceptance is allowed.
- Latency: rsp_valid rises SETUP_CYC+STROBE_CYC+HOLD_CYC+RECOVER_CYC cycles after the accept edge (5 with defaults). Throughput is one access per 6 cycles with defaults.
- Bus exclusivity:
  - RD_n and WR_n are never low simultaneously.
  - DATA is never driven while RD_n = 0.
  - DATA is never driven in IDLE or RECOVER.
- busy = 1 in every state except IDLE.

Optional Feature:
- Macro: INIT_CFG_EN.
- Defined:
  - After reset the FSM enters INIT and performs one full write cycle of INIT_CTRL_WORD to A = 11 with normal timing.
  - req_ready stays 0 until that cycle completes; no rsp_valid is generated for it.
  - busy = 1 during INIT.
- Undefined: the INIT state is absent and req_ready = 1 in the first cycle after RESET deasserts.

Test Plan:
- Reset: hold RESET 3 cycles, release -> CS_n=RD_n=WR_n=1, DATA=Z, rsp_rdata=00, req_ready=1 (no INIT_CFG_EN).
- Control write: req write addr=11 data=8'h80 -> CS_n low 4 cycles, WR_n low exactly cycles 2-3 after accept, A=11, DATA=80 throughout CS_n low, rsp_valid pulse 5 cycles after accept.
- Port read: PPI model drives 8'h5A on port A; req read addr=00 -> RD_n low 2 cycles, DATA never driven by master, rsp_rdata=5A with rsp_valid; a subsequent write leaves rsp_rdata=5A.
- Back-to-back: req_valid held high with write B=8'h33 then read C -> second accept on the same cycle as the first rsp_valid; no overlap of CS_n low periods; RECOVER gap of 1 cycle with CS_n high.
- Reset mid-access: assert RESET during STROBE of a write -> WR_n=1, CS_n=1, DATA=Z at the next edge; no rsp_valid; next request completes normally.
- INIT_CFG_EN defined: release reset -> one write of 9B to A=11 occurs, req_ready=0 until its completion, no rsp_valid pulse, then req_ready=1.
